// File: rtl/control_unit.sv
// control_unit: ARM-style instruction decoder with a two-stage control pipeline.
//   The ID stage decodes instr combinationally into id_* control values. The
//   ID/EX register captures them into ex_* (or a bubble when nop_sel=1). The
//   EX/MEM register then passes the memory-related subset on to mem_*.
// Ports:
//   CLK, CLR     - clock and synchronous active-high clear of both stages
//   instr        - 32-bit instruction in ID; the condition field is ignored
//   nop_sel      - forces a bubble (all zero) into ID/EX
//   id_*         - combinational decode outputs
//   ex_*         - ID/EX registered controls (id_b_instr is not carried)
//   mem_*        - EX/MEM registered memory/writeback controls
module control_unit (
  input  logic        CLK,
  input  logic        CLR,
  input  logic [31:0] instr,
  input  logic        nop_sel,
  output logic        id_shift_imm,
  output logic [3:0]  id_alu_op,
  output logic        id_size,
  output logic        id_mem_en,
  output logic        id_rw,
  output logic        id_load,
  output logic        id_s,
  output logic        id_rf_en,
  output logic        id_b_instr,
  output logic        ex_shift_imm,
  output logic [3:0]  ex_alu_op,
  output logic        ex_size,
  output logic        ex_mem_en,
  output logic        ex_rw,
  output logic        ex_load,
  output logic        ex_s,
  output logic        ex_rf_en,
  output logic        mem_size,
  output logic        mem_mem_en,
  output logic        mem_rw,
  output logic        mem_load,
  output logic        mem_rf_en
);

  localparam logic [3:0] AluAdd = 4'b0100;
  localparam logic [3:0] AluSub = 4'b0010;

  logic [3:0] w_opcode;
  logic       w_is_nop;
  logic       w_is_cmp_class;

  assign w_opcode       = instr[24:21];
  assign w_is_nop       = (instr == 32'h0);
  // TST/TEQ/CMP/CMN only set flags, so they never write the register file.
  assign w_is_cmp_class = (w_opcode[3:2] == 2'b10);

  // ID decode
  always_comb begin
    id_shift_imm = 1'b0;
    id_alu_op    = 4'b0000;
    id_size      = 1'b0;
    id_mem_en    = 1'b0;
    id_rw        = 1'b0;
    id_load      = 1'b0;
    id_s         = 1'b0;
    id_rf_en     = 1'b0;
    id_b_instr   = 1'b0;
    if (!w_is_nop) begin
      if (instr[27:26] == 2'b00) begin
        // Data processing
        id_shift_imm = 1'b1;
        id_alu_op    = w_opcode;
        id_s         = instr[20];
        id_rf_en     = ~w_is_cmp_class;
      end else if (instr[27:26] == 2'b01) begin
        // Load/store: U bit chooses add or subtract of the offset
        id_shift_imm = 1'b1;
        id_mem_en    = 1'b1;
        id_size      = instr[22];
        id_load      = instr[20];
        id_rw        = ~instr[20];
        id_rf_en     = instr[20];
        id_alu_op    = instr[23] ? AluAdd : AluSub;
      end else if (instr[27:25] == 3'b101) begin
        // Branch; the link bit makes BL write the link register
        id_b_instr   = 1'b1;
        id_rf_en     = instr[24];
        id_alu_op    = AluAdd;
      end
    end
  end

  // ID/EX and EX/MEM pipeline registers
  always_ff @(posedge CLK) begin
    if (CLR) begin
      ex_shift_imm <= 1'b0;
      ex_alu_op    <= 4'b0000;
      ex_size      <= 1'b0;
      ex_mem_en    <= 1'b0;
      ex_rw        <= 1'b0;
      ex_load      <= 1'b0;
      ex_s         <= 1'b0;
      ex_rf_en     <= 1'b0;
      mem_size     <= 1'b0;
      mem_mem_en   <= 1'b0;
      mem_rw       <= 1'b0;
      mem_load     <= 1'b0;
      mem_rf_en    <= 1'b0;
    end else begin
      if (nop_sel) begin
        ex_shift_imm <= 1'b0;
        ex_alu_op    <= 4'b0000;
        ex_size      <= 1'b0;
        ex_mem_en    <= 1'b0;
        ex_rw        <= 1'b0;
        ex_load      <= 1'b0;
        ex_s         <= 1'b0;
        ex_rf_en     <= 1'b0;
      end else begin
        ex_shift_imm <= id_shift_imm;
        ex_alu_op    <= id_alu_op;
        ex_size      <= id_size;
        ex_mem_en    <= id_mem_en;
        ex_rw        <= id_rw;
        ex_load      <= id_load;
        ex_s         <= id_s;
        ex_rf_en     <= id_rf_en;
      end
      mem_size   <= ex_size;
      mem_mem_en <= ex_mem_en;
      mem_rw     <= ex_rw;
      mem_load   <= ex_load;
      mem_rf_en  <= ex_rf_en;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  logic        CLK = 1'b0;
  logic        CLR;
  logic [31:0] instr;
  logic        nop_sel;
  logic        id_shift_imm, id_size, id_mem_en, id_rw, id_load, id_s, id_rf_en, id_b_instr;
  logic [3:0]  id_alu_op;
  logic        ex_shift_imm, ex_size, ex_mem_en, ex_rw, ex_load, ex_s, ex_rf_en;
  logic [3:0]  ex_alu_op;
  logic        mem_size, mem_mem_en, mem_rw, mem_load, mem_rf_en;

  int checks = 0;
  int errors = 0;

  // {shift_imm, alu_op, size, mem_en, rw, load, s, rf_en, b_instr}
  logic [11:0] id_vec;
  logic [10:0] ex_vec;
  // {size, mem_en, rw, load, rf_en}
  logic [4:0]  mem_vec;
  assign id_vec  = {id_shift_imm, id_alu_op, id_size, id_mem_en, id_rw, id_load, id_s,
                    id_rf_en, id_b_instr};
  assign ex_vec  = {ex_shift_imm, ex_alu_op, ex_size, ex_mem_en, ex_rw, ex_load, ex_s,
                    ex_rf_en};
  assign mem_vec = {mem_size, mem_mem_en, mem_rw, mem_load, mem_rf_en};

  localparam logic [11:0] IdAdd  = 12'b1_0100_0000_010;
  localparam logic [11:0] IdSubs = 12'b1_0010_0000_110;
  localparam logic [11:0] IdCmp  = 12'b1_1010_0000_100;
  localparam logic [11:0] IdStrb = 12'b1_0100_1110_000;
  localparam logic [11:0] IdLdr  = 12'b1_0100_0101_010;
  localparam logic [11:0] IdLdrU = 12'b1_0010_0101_010;
  localparam logic [11:0] IdBne  = 12'b0_0100_0000_001;
  localparam logic [11:0] IdBl   = 12'b0_0100_0000_011;

  control_unit dut (
    .CLK(CLK), .CLR(CLR), .instr(instr), .nop_sel(nop_sel),
    .id_shift_imm(id_shift_imm), .id_alu_op(id_alu_op), .id_size(id_size),
    .id_mem_en(id_mem_en), .id_rw(id_rw), .id_load(id_load), .id_s(id_s),
    .id_rf_en(id_rf_en), .id_b_instr(id_b_instr),
    .ex_shift_imm(ex_shift_imm), .ex_alu_op(ex_alu_op), .ex_size(ex_size),
    .ex_mem_en(ex_mem_en), .ex_rw(ex_rw), .ex_load(ex_load), .ex_s(ex_s),
    .ex_rf_en(ex_rf_en),
    .mem_size(mem_size), .mem_mem_en(mem_mem_en), .mem_rw(mem_rw),
    .mem_load(mem_load), .mem_rf_en(mem_rf_en)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    CLR = 1'b1; nop_sel = 1'b0; instr = 32'hE0825005;
    step(); step();
    checks++;
    if (ex_vec !== 11'h0) begin
      errors++; $display("FAIL reset_ex: got %b expected %b", ex_vec, 11'h0);
    end
    checks++;
    if (mem_vec !== 5'h0) begin
      errors++; $display("FAIL reset_mem: got %b expected %b", mem_vec, 5'h0);
    end
    checks++;
    #1;
    if (id_vec !== IdAdd) begin
      errors++; $display("FAIL reset_id_comb: got %b expected %b", id_vec, IdAdd);
    end
    CLR = 1'b0;
  endtask

  task automatic test_add();
    instr = 32'hE0825005; #1;
    checks++;
    if (id_vec !== IdAdd) begin
      errors++; $display("FAIL add_id: got %b expected %b", id_vec, IdAdd);
    end
    step();
    checks++;
    if (ex_vec !== IdAdd[11:1]) begin
      errors++; $display("FAIL add_ex: got %b expected %b", ex_vec, IdAdd[11:1]);
    end
    step();
    checks++;
    if (mem_vec !== 5'b0000_1) begin
      errors++; $display("FAIL add_mem: got %b expected %b", mem_vec, 5'b00001);
    end
  endtask

  task automatic test_dp_flags();
    instr = 32'hE2533001; #1;
    checks++;
    if (id_vec !== IdSubs) begin
      errors++; $display("FAIL subs_id: got %b expected %b", id_vec, IdSubs);
    end
    step();
    checks++;
    if (ex_vec !== IdSubs[11:1]) begin
      errors++; $display("FAIL subs_ex: got %b expected %b", ex_vec, IdSubs[11:1]);
    end
    instr = 32'hE1530004; #1;
    checks++;
    if (id_vec !== IdCmp) begin
      errors++; $display("FAIL cmp_id: got %b expected %b", id_vec, IdCmp);
    end
    // TST opcode 1000 and ORR opcode 1100 bracket the no-writeback range
    instr = 32'hE1100000; #1;
    checks++;
    if (id_rf_en !== 1'b0) begin
      errors++; $display("FAIL tst_rf_en: got %b expected 0", id_rf_en);
    end
    instr = 32'hE1800000; #1;
    checks++;
    if (id_rf_en !== 1'b1) begin
      errors++; $display("FAIL orr_rf_en: got %b expected 1", id_rf_en);
    end
  endtask

  task automatic test_load_store();
    instr = 32'hE5C15003; #1;
    checks++;
    if (id_vec !== IdStrb) begin
      errors++; $display("FAIL strb_id: got %b expected %b", id_vec, IdStrb);
    end
    step(); step();
    checks++;
    if (mem_vec !== 5'b11100) begin
      errors++; $display("FAIL strb_mem: got %b expected %b", mem_vec, 5'b11100);
    end
    instr = 32'hE5912000; #1;
    checks++;
    if (id_vec !== IdLdr) begin
      errors++; $display("FAIL ldr_id: got %b expected %b", id_vec, IdLdr);
    end
    instr = 32'hE5112004; #1;
    checks++;
    if (id_vec !== IdLdrU) begin
      errors++; $display("FAIL ldr_sub_id: got %b expected %b", id_vec, IdLdrU);
    end
  endtask

  task automatic test_branch_misc();
    instr = 32'h1AFFFFFD; #1;
    checks++;
    if (id_vec !== IdBne) begin
      errors++; $display("FAIL bne_id: got %b expected %b", id_vec, IdBne);
    end
    instr = 32'hDB000001; #1;
    checks++;
    if (id_vec !== IdBl) begin
      errors++; $display("FAIL blle_id: got %b expected %b", id_vec, IdBl);
    end
    step();
    checks++;
    if (ex_vec !== IdBl[11:1]) begin
      errors++; $display("FAIL blle_ex: got %b expected %b", ex_vec, IdBl[11:1]);
    end
    instr = 32'h00000000; #1;
    checks++;
    if (id_vec !== 12'h0) begin
      errors++; $display("FAIL nop_id: got %b expected %b", id_vec, 12'h0);
    end
    instr = 32'hEC000000; #1;
    checks++;
    if (id_vec !== 12'h0) begin
      errors++; $display("FAIL coproc_id: got %b expected %b", id_vec, 12'h0);
    end
    instr = 32'hE8900000; #1;
    checks++;
    if (id_vec !== 12'h0) begin
      errors++; $display("FAIL ldm_id: got %b expected %b", id_vec, 12'h0);
    end
  endtask

  task automatic test_back_to_back();
    instr = 32'hE0825005;
    step();
    instr = 32'hE5C15003;
    step();
    checks++;
    if (ex_vec !== IdStrb[11:1]) begin
      errors++; $display("FAIL b2b_ex: got %b expected %b", ex_vec, IdStrb[11:1]);
    end
    checks++;
    if (mem_vec !== 5'b00001) begin
      errors++; $display("FAIL b2b_mem: got %b expected %b", mem_vec, 5'b00001);
    end
  endtask

  task automatic test_clr_flush();
    instr = 32'hE0825005;
    step(); step();
    CLR = 1'b1;
    step();
    checks++;
    if (ex_vec !== 11'h0 || mem_vec !== 5'h0) begin
      errors++; $display("FAIL clr_flush: got ex %b mem %b expected zero", ex_vec, mem_vec);
    end
    CLR = 1'b0;
    step();
    checks++;
    if (ex_vec !== IdAdd[11:1] || mem_vec !== 5'h0) begin
      errors++; $display("FAIL clr_resume1: got ex %b mem %b expected ex %b mem 0",
                         ex_vec, mem_vec, IdAdd[11:1]);
    end
    step();
    checks++;
    if (mem_vec !== 5'b00001) begin
      errors++; $display("FAIL clr_resume2: got %b expected %b", mem_vec, 5'b00001);
    end
  endtask

  task automatic test_nop_sel();
    instr = 32'hE0825005; nop_sel = 1'b1;
    step();
    checks++;
    if (ex_vec !== 11'h0) begin
      errors++; $display("FAIL nop_sel_ex: got %b expected %b", ex_vec, 11'h0);
    end
    checks++;
    if (mem_vec !== 5'b00001) begin
      errors++; $display("FAIL nop_sel_mem: got %b expected %b", mem_vec, 5'b00001);
    end
    nop_sel = 1'b0;
    step();
    checks++;
    if (mem_vec !== 5'h0 || ex_vec !== IdAdd[11:1]) begin
      errors++; $display("FAIL nop_sel_after: got ex %b mem %b", ex_vec, mem_vec);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_dp_flags();
    test_load_store();
    test_branch_misc();
    test_back_to_back();
    test_clr_flush();
    test_nop_sel();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
